// File: rtl/display_scanner.sv
// Four-digit multiplexed display scanner: prescaled digit rotation, frame-aligned
// value commit and optional leading-zero blanking, with all outputs registered.
module display_scanner #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        load,
  input  logic        blank_lz,
  output logic [3:0]  digit_code,
  output logic [3:0]  anode,
  output logic [1:0]  digit_sel,
  output logic        tick
);

  localparam logic [15:0] TERMINAL = 16'(REFRESH_DIV - 1);

  logic [15:0] presc_q;
  logic [15:0] hold_q;
  logic [15:0] disp_q;
  logic        pending_q;

  logic        at_tc;
  logic        commit;
  logic [15:0] disp_next;
  logic [1:0]  sel_next;
  logic        blank_next;
  logic [3:0]  code_next;
  logic [3:0]  anode_next;

  // Outputs are computed from the post-edge digit index and display contents,
  // so the first digit of a new frame already shows the committed value.
  always_comb begin
    at_tc      = (presc_q == TERMINAL);
    commit     = at_tc && (digit_sel == 2'd3) && pending_q;
    disp_next  = commit ? hold_q : disp_q;
    sel_next   = digit_sel + 2'd1;
    blank_next = 1'b0;
    unique case (sel_next)
      2'd3:    blank_next = (disp_next[15:12] == 4'h0);
      2'd2:    blank_next = (disp_next[15:8]  == 8'h00);
      2'd1:    blank_next = (disp_next[15:4]  == 12'h000);
      default: blank_next = 1'b0;
    endcase
    blank_next = blank_next && blank_lz;
    code_next  = blank_next ? 4'h0 : disp_next[{sel_next, 2'b00} +: 4];
    anode_next = blank_next ? 4'b0000 : (4'b0001 << sel_next);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; that is what lets a load on the wrap edge commit
  // the old hold contents while hold itself takes the new value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q    <= '0;
      digit_sel  <= '0;
      hold_q     <= '0;
      disp_q     <= '0;
      pending_q  <= 1'b0;
      digit_code <= 4'h0;
      anode      <= 4'b0001;
      tick       <= 1'b0;
    end else begin
      presc_q <= at_tc ? 16'd0 : presc_q + 16'd1;
      tick    <= at_tc;

      if (at_tc) begin
        digit_sel  <= sel_next;
        digit_code <= code_next;
        anode      <= anode_next;
      end

      if (commit)
        disp_q <= hold_q;

      // A load always wins over the wrap clear so a value arriving on the
      // commit edge is kept for the following frame.
      if (load) begin
        hold_q    <= value;
        pending_q <= 1'b1;
      end else if (commit) begin
        pending_q <= 1'b0;
      end
    end
  end

endmodule
